// File: rtl/seg_scan_pkg.sv
// Shared types, segment patterns and code constants for the seven-segment scan capture path.
package seg_scan_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned CODE_W     = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIG_IDX_W  = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned ERRCNT_W   = 8;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [SEG_W-1:0] SEG_PAT_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_PAT_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_PAT_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_PAT_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_PAT_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_PAT_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_PAT_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_PAT_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_PAT_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_PAT_9     = 7'b0001100;
  localparam logic [SEG_W-1:0] SEG_PAT_DASH  = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_PAT_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] SEG_PAT_BLANK = 7'b1111111;

  localparam logic [CODE_W-1:0] CODE_DASH    = 4'd10;
  localparam logic [CODE_W-1:0] CODE_F       = 4'd11;
  localparam logic [CODE_W-1:0] CODE_BLANK   = 4'd12;
  localparam logic [CODE_W-1:0] CODE_ILLEGAL = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILTER  = 2'd1,
    ST_HELD    = 2'd2,
    ST_COLLIDE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    AN_BLANK   = 2'd0,
    AN_SINGLE  = 2'd1,
    AN_COLLIDE = 2'd2
  } an_class_e;

  typedef struct packed {
    logic              illegal;
    logic [CODE_W-1:0] code;
  } seg_decode_t;

  // Classify the active-low anode vector as gap, single digit window or collision.
  function automatic an_class_e classify_an(input logic [NUM_DIGITS-1:0] an);
    an_class_e cls;
    case (an)
      4'b1111:                            cls = AN_BLANK;
      4'b0111, 4'b1011, 4'b1101, 4'b1110: cls = AN_SINGLE;
      default:                            cls = AN_COLLIDE;
    endcase
    return cls;
  endfunction

  // Index of the single low anode; only meaningful for an AN_SINGLE vector.
  function automatic logic [DIG_IDX_W-1:0] active_digit(input logic [NUM_DIGITS-1:0] an);
    logic [DIG_IDX_W-1:0] idx;
    case (an)
      4'b0111: idx = DIG_IDX_W'(3);
      4'b1011: idx = DIG_IDX_W'(2);
      4'b1101: idx = DIG_IDX_W'(1);
      default: idx = DIG_IDX_W'(0);
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational seven-segment pattern to character code decoder; unknown patterns map to
// CODE_ILLEGAL with the illegal flag set.
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output seg_decode_t      dec_c
);

  always_comb begin
    dec_c.illegal = 1'b0;
    dec_c.code    = CODE_BLANK;
    case (seg)
      SEG_PAT_0:     dec_c.code = CODE_W'(0);
      SEG_PAT_1:     dec_c.code = CODE_W'(1);
      SEG_PAT_2:     dec_c.code = CODE_W'(2);
      SEG_PAT_3:     dec_c.code = CODE_W'(3);
      SEG_PAT_4:     dec_c.code = CODE_W'(4);
      SEG_PAT_5:     dec_c.code = CODE_W'(5);
      SEG_PAT_6:     dec_c.code = CODE_W'(6);
      SEG_PAT_7:     dec_c.code = CODE_W'(7);
      SEG_PAT_8:     dec_c.code = CODE_W'(8);
      SEG_PAT_9:     dec_c.code = CODE_W'(9);
      SEG_PAT_DASH:  dec_c.code = CODE_DASH;
      SEG_PAT_F:     dec_c.code = CODE_F;
      SEG_PAT_BLANK: dec_c.code = CODE_BLANK;
      default: begin
        dec_c.code    = CODE_ILLEGAL;
        dec_c.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed four-digit seven-segment display: debounces each digit
// window, decodes it and publishes complete 3..0 frames. SEG_CAPTURE_ERRCNT_EN adds err_cnt.
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              an3,
  input  logic              an2,
  input  logic              an1,
  input  logic              an0,
  input  logic [SEG_W-1:0]  seg,
  output logic [CODE_W-1:0] char3,
  output logic [CODE_W-1:0] char2,
  output logic [CODE_W-1:0] char1,
  output logic [CODE_W-1:0] char0,
  output logic              frame_valid,
  output logic              seg_err
`ifdef SEG_CAPTURE_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned      SAMPLE_W   = NUM_DIGITS + SEG_W;
  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [NUM_DIGITS-1:0]             an;
  logic [NUM_DIGITS-1:0]             an_q;
  logic [SAMPLE_W-1:0]               sample;
  logic [SAMPLE_W-1:0]               sample_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic [CNT_W-1:0]                  cnt_nxt_c;
  an_class_e                         an_cls_c;
  logic                              an_changed_c;
  logic [DIG_IDX_W-1:0]              digit_c;
  seg_decode_t                       dec_c;
  state_e                            state_q;
  state_e                            state_d;
  logic                              capture_c;
  logic                              collide_entry_c;
  logic [NUM_DIGITS-1:0]             mask_q;
  logic [NUM_DIGITS-1:0][CODE_W-1:0] shadow_q;
  logic                              frame_pend_q;
  logic                              err_pend_q;

  assign an           = {an3, an2, an1, an0};
  assign sample       = {an, seg};
  assign an_q         = sample_q[SAMPLE_W-1 -: NUM_DIGITS];
  assign an_cls_c     = classify_an(an);
  assign an_changed_c = (an != an_q);
  assign digit_c      = active_digit(an);

  seg_pattern_decode u_decode (
    .seg   (seg),
    .dec_c (dec_c)
  );

  // Stability counter: restarts at 1 on any change of the sampled bus, saturates otherwise.
  always_comb begin
    cnt_nxt_c = CNT_MAX;
    if (sample != sample_q) begin
      cnt_nxt_c = CNT_W'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_nxt_c = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A window already held only leaves HELD when the anode vector itself changes.
  always_comb begin
    state_d = state_q;
    case (an_cls_c)
      AN_COLLIDE: state_d = ST_COLLIDE;
      AN_BLANK:   state_d = ST_IDLE;
      default: begin
        if (state_q == ST_HELD && !an_changed_c) begin
          state_d = ST_HELD;
        end else if (cnt_nxt_c == STABLE_CNT) begin
          state_d = ST_HELD;
        end else begin
          state_d = ST_FILTER;
        end
      end
    endcase
  end

  always_comb begin
    capture_c       = 1'b0;
    collide_entry_c = 1'b0;
    if (state_d == ST_COLLIDE && state_q != ST_COLLIDE) begin
      collide_entry_c = 1'b1;
    end
    if (state_d == ST_HELD && (state_q != ST_HELD || an_changed_c)) begin
      capture_c = 1'b1;
    end
  end

  // Capture datapath: shadows, frame mask and one-cycle pending flags for the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q     <= '1;
      cnt_q        <= '0;
      mask_q       <= '0;
      shadow_q     <= {NUM_DIGITS{CODE_BLANK}};
      frame_pend_q <= 1'b0;
      err_pend_q   <= 1'b0;
    end else begin
      sample_q     <= sample;
      cnt_q        <= cnt_nxt_c;
      frame_pend_q <= 1'b0;
      err_pend_q   <= 1'b0;
      if (collide_entry_c) begin
        mask_q     <= '0;
        err_pend_q <= 1'b1;
      end else if (capture_c) begin
        shadow_q[digit_c] <= dec_c.code;
        err_pend_q        <= dec_c.illegal;
        case (digit_c)
          DIG_IDX_W'(3): mask_q <= 4'b1000;
          DIG_IDX_W'(0): begin
            frame_pend_q <= &mask_q[NUM_DIGITS-1:1];
            mask_q       <= '0;
          end
          default: mask_q[digit_c] <= 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char3       <= CODE_BLANK;
      char2       <= CODE_BLANK;
      char1       <= CODE_BLANK;
      char0       <= CODE_BLANK;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      frame_valid <= frame_pend_q;
      seg_err     <= err_pend_q;
      if (frame_pend_q) begin
        char3 <= shadow_q[3];
        char2 <= shadow_q[2];
        char1 <= shadow_q[1];
        char0 <= shadow_q[0];
      end
    end
  end

`ifdef SEG_CAPTURE_ERRCNT_EN
  // Saturating count of seg_err pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (seg_err && err_cnt != '1) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed and random run lists checked cycle by cycle against a
// run-level reference model of the display protocol.
module tb_seg_scan_capture;

  localparam int unsigned S     = 2;
  localparam int          FLUSH = 4;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    int         len;
  } run_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an_bus;
  logic [6:0] seg;
  logic [3:0] char3, char2, char1, char0;
  logic       frame_valid, seg_err;
`ifdef SEG_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int total = 0;
  int bad   = 0;

  run_t       runs[$];
  logic [6:0] pat_tab [13];
  logic [3:0] coll_tab [6];
  logic [3:0] m_shadow [4];
  logic [3:0] m_mask;
  logic [15:0] m_chars;
  int         m_err_total;
  int         prev_kind;

  seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .reset       (reset),
    .an3         (an_bus[3]),
    .an2         (an_bus[2]),
    .an1         (an_bus[1]),
    .an0         (an_bus[0]),
    .seg         (seg),
    .char3       (char3),
    .char2       (char2),
    .char1       (char1),
    .char0       (char0),
    .frame_valid (frame_valid),
    .seg_err     (seg_err)
`ifdef SEG_CAPTURE_ERRCNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int cyc, input logic [15:0] got,
                       input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    for (int k = 0; k < 13; k++) begin
      if (pat_tab[k] == s) return {1'b0, 4'(k)};
    end
    return {1'b1, 4'hF};
  endfunction

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_shadow[k] = 4'hC;
    m_mask      = 4'b0000;
    m_chars     = 16'hCCCC;
    m_err_total = 0;
    prev_kind   = 0;
  endtask

  task automatic add(input logic [3:0] a, input logic [6:0] s, input int len);
    if (len > 0) runs.push_back('{an: a, seg: s, len: len});
  endtask

  task automatic add_digit(input int d, input logic [6:0] s, input int len, input int gap);
    add(an_of(d), s, len);
    add(4'hF, 7'h7F, gap);
  endtask

  // Expand the run list into cycles, predict outputs per cycle from run-level rules, then drive.
  task automatic play();
    int          n;
    int          t;
    logic [3:0]  c_an[];
    logic [6:0]  c_seg[];
    bit          e_fv[];
    bit          e_err[];
    logic [15:0] e_upd[];
    logic [15:0] cur;
    runs.push_back('{an: 4'hF, seg: 7'h7F, len: FLUSH});
    n = 0;
    foreach (runs[r]) n += runs[r].len;
    c_an  = new[n];
    c_seg = new[n];
    e_fv  = new[n];
    e_err = new[n];
    e_upd = new[n];
    cur   = m_chars;
    t     = 0;
    foreach (runs[r]) begin
      int zeros;
      zeros = 4 - $countones(runs[r].an);
      for (int k = 0; k < runs[r].len; k++) begin
        c_an[t+k]  = runs[r].an;
        c_seg[t+k] = runs[r].seg;
      end
      if (zeros >= 2) begin
        if (prev_kind != 2) begin
          m_mask     = 4'b0000;
          e_err[t+1] = 1'b1;
          m_err_total++;
        end
        prev_kind = 2;
      end else if (zeros == 0) begin
        prev_kind = 0;
      end else begin
        prev_kind = 1;
        if (runs[r].len >= int'(S)) begin
          int         d;
          int         ce;
          logic [4:0] dec;
          ce = t + int'(S) - 1;
          d  = 0;
          for (int k = 0; k < 4; k++) if (!runs[r].an[k]) d = k;
          dec         = ref_decode(runs[r].seg);
          m_shadow[d] = dec[3:0];
          if (dec[4]) begin
            e_err[ce+1] = 1'b1;
            m_err_total++;
          end
          if (d == 3) begin
            m_mask = 4'b1000;
          end else if (d == 0) begin
            if (m_mask[3:1] == 3'b111) begin
              m_chars     = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
              e_fv[ce+1]  = 1'b1;
              e_upd[ce+1] = m_chars;
            end
            m_mask = 4'b0000;
          end else begin
            m_mask[d] = 1'b1;
          end
        end
      end
      t += runs[r].len;
    end
    for (int i = 0; i < n; i++) begin
      an_bus = c_an[i];
      seg    = c_seg[i];
      @(posedge clk);
      #1;
      if (e_fv[i]) cur = e_upd[i];
      check("frame_valid", i, 16'(frame_valid), 16'(e_fv[i]));
      check("seg_err", i, 16'(seg_err), 16'(e_err[i]));
      check("chars", i, {char3, char2, char1, char0}, cur);
    end
`ifdef SEG_CAPTURE_ERRCNT_EN
    check("err_cnt", n, 16'(err_cnt), 16'((m_err_total > 255) ? 255 : m_err_total));
`endif
    runs.delete();
  endtask

  initial begin
    pat_tab  = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b1111110, 7'b0111000,
                 7'b1111111};
    coll_tab = '{4'b0011, 4'b0101, 4'b1001, 4'b0000, 4'b1100, 4'b0110};
    reset  = 1'b0;
    an_bus = 4'hF;
    seg    = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_chars", 0, {char3, char2, char1, char0}, 16'hCCCC);
    check("rst_fv", 0, 16'(frame_valid), 16'h0);
    check("rst_err", 0, 16'(seg_err), 16'h0);
`ifdef SEG_CAPTURE_ERRCNT_EN
    check("rst_errcnt", 0, 16'(err_cnt), 16'h0);
`endif
    reset = 1'b1;

    // Two clean frames 1,2,3,4 with driver-like 16-cycle windows and gaps
    for (int f = 0; f < 2; f++) begin
      add_digit(3, pat_tab[1], 16, 16);
      add_digit(2, pat_tab[2], 16, 16);
      add_digit(1, pat_tab[3], 16, 16);
      add_digit(0, pat_tab[4], 16, 16);
    end
    play();
    check("frame_1234", 0, {char3, char2, char1, char0}, 16'h1234);

    // Digit 2 window of one cycle: frame dropped, chars hold
    add_digit(3, pat_tab[5], 16, 16);
    add_digit(2, pat_tab[6], 1, 16);
    add_digit(1, pat_tab[7], 16, 16);
    add_digit(0, pat_tab[8], 16, 16);
    play();
    check("short_hold", 0, {char3, char2, char1, char0}, 16'h1234);

    // Illegal pattern on digit 1
    add_digit(3, pat_tab[1], 16, 16);
    add_digit(2, pat_tab[2], 16, 16);
    add_digit(1, 7'b1010101, 16, 16);
    add_digit(0, pat_tab[4], 16, 16);
    play();
    check("illegal_frame", 0, {char3, char2, char1, char0}, 16'h12F4);

    // Collision mid-frame, then a clean frame
    add_digit(3, pat_tab[9], 16, 4);
    add_digit(2, pat_tab[8], 16, 0);
    add(4'b0011, pat_tab[8], 4);
    add(4'hF, 7'h7F, 4);
    add_digit(1, pat_tab[7], 16, 4);
    add_digit(0, pat_tab[6], 16, 8);
    play();
    check("collide_hold", 0, {char3, char2, char1, char0}, 16'h12F4);
    add_digit(3, pat_tab[9], 16, 4);
    add_digit(2, pat_tab[8], 16, 4);
    add_digit(1, pat_tab[7], 16, 4);
    add_digit(0, pat_tab[6], 16, 4);
    play();
    check("frame_9876", 0, {char3, char2, char1, char0}, 16'h9876);

    // Reset after digits 3 and 2, then digits 1 and 0 only
    add_digit(3, pat_tab[3], 16, 4);
    add_digit(2, pat_tab[3], 16, 4);
    play();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check("midrst_chars", 0, {char3, char2, char1, char0}, 16'hCCCC);
    check("midrst_fv", 0, 16'(frame_valid), 16'h0);
    check("midrst_err", 0, 16'(seg_err), 16'h0);
    reset = 1'b1;
    add_digit(1, pat_tab[5], 16, 4);
    add_digit(0, pat_tab[5], 16, 4);
    play();
    check("partial_chars", 0, {char3, char2, char1, char0}, 16'hCCCC);

    // Random frames with short windows, odd patterns, back-to-back windows and collisions
    for (int f = 0; f < 30; f++) begin
      for (int d = 3; d >= 0; d--) begin
        int         lsel;
        int         wl;
        logic [6:0] p;
        if ($urandom_range(0, 9) == 0) begin
          add(coll_tab[$urandom_range(0, 5)], pat_tab[$urandom_range(0, 12)],
              int'($urandom_range(1, 5)));
          add(4'hF, 7'h7F, int'($urandom_range(1, 3)));
        end
        if ($urandom_range(0, 7) == 0) p = 7'($urandom);
        else p = pat_tab[$urandom_range(0, 12)];
        lsel = int'($urandom_range(0, 4));
        wl   = (lsel == 0) ? 1 : (lsel == 1) ? 2 : (lsel == 2) ? 3 : 16;
        add_digit(d, p, wl, int'($urandom_range(0, 3)));
      end
    end
    play();

`ifdef SEG_CAPTURE_ERRCNT_EN
    // 300 illegal digits saturate the error counter, which then holds
    for (int k = 0; k < 300; k++) add_digit(k % 4, 7'b1010101, 2, 1);
    play();
    check("errcnt_sat", 0, 16'(err_cnt), 16'd255);
    for (int k = 0; k < 3; k++) add_digit(k, 7'b1010101, 2, 1);
    play();
    check("errcnt_hold", 0, 16'(err_cnt), 16'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

Receive-side counterpart of the four-digit multiplexed seven-segment driver. It monitors the active-low anode strobes and the shared segment bus, debounces each digit window, and decodes each segment pattern back to its 4-bit character code. It reassembles complete frames (digit 3 down to digit 0) and presents them as parallel character registers. It sits in self-check and loopback benches, or beside the driver on-chip, to confirm the displayed content.

## Interface
- STABLE_CYCLES, default 2: consecutive identical samples required before a digit is captured. Legal range 1..15.
- clk  in  1  clock; all inputs synchronous to it.
- reset  in  1  asynchronous, active-low.
- an3, an2, an1, an0  in  1 each  anode strobes, active-low; an3 = leftmost digit.
- seg  in  7  segments {a,b,c,d,e,f,g}; bit 6 = a; active-low (0 = lit).
- char3, char2, char1, char0  out  4 each  last complete decoded frame.
- frame_valid  out  1  one-cycle pulse when char3..char0 update.
- seg_err  out  1  one-cycle pulse on illegal pattern or anode collision.

## Operation
- Decode map, seg to code:
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0001100→9
  - 1111110→10 (dash), 0111000→11 (F), 1111111→12 (blank)
  - any other pattern→15 and is flagged illegal.
- Anode classification of {an3,an2,an1,an0}:
  - exactly one bit low: digit window for that digit.
  - all high: blank gap.
  - two or more low: collision.
- Filter counter: 4-bit, saturating. Reloads to 1 whenever {an,seg} differs from the previous cycle's sample; otherwise increments.
- FSM states:
  - IDLE: blank gap, or reset exit.
  - FILTER: digit window, counter below STABLE_CYCLES.
  - HELD: digit captured; stays here until the anode vector changes.
  - COLLIDE: two or more anodes low.
- Transitions:
  - Any state with a new single-low vector → FILTER.
  - All high → IDLE.
  - Two or more low → COLLIDE.
  - FILTER with counter == STABLE_CYCLES → HELD, capturing the digit.
- Capture writes the decoded code to that digit's shadow register and sets its bit in a 4-bit frame mask.
  - Illegal pattern: code 15 is stored and seg_err pulses.
  - Segment changes while in HELD are ignored.
- Frame completion: on capture of digit 0, if the mask is 1111, copy shadows to char3..char0 and pulse frame_valid. Clear the mask on every digit-0 capture, whether or not the frame completed.
- Digit-3 capture clears the mask to 1000 (start of frame).
- Entering COLLIDE pulses seg_err once and clears the mask. No capture occurs in COLLIDE.

## Timing
- Reset values:
  - char3..char0 = 4'hC (blank)
  - frame_valid = 0, seg_err = 0
  - mask = 0, shadows = 4'hC, counter = 0, state = IDLE.
- Capture latency: an input stable from cycle t is captured at the edge closing cycle t+STABLE_CYCLES-1.
- char outputs and frame_valid register one edge after the digit-0 capture edge.
- seg_err asserts at the edge after the capture or collision-detect edge. It lasts exactly one cycle.
- A window shorter than STABLE_CYCLES cycles is never captured, so the frame misses a digit and no frame_valid is produced.
- Simultaneous events within one edge:
  - collision beats capture.
  - mask clear on digit 0 takes effect after the completion check.
- Reset mid-frame: all state returns to reset values immediately; no frame_valid is produced for the partial frame.
- Compatible with the driver's 16-clk digit windows for any STABLE_CYCLES ≤ 15.

## Configuration
- SEG_CAPTURE_ERRCNT_EN defined:
  - adds output err_cnt, out, 8 bits.
  - increments on every seg_err pulse and saturates at 255.
  - reset value 0.
- Undefined: the err_cnt port and its counter do not exist.

## Structure
- Shared package seg_scan_pkg holds:
  - segment-pattern localparams for codes 0..12.
  - code constants CODE_DASH=10, CODE_F=11, CODE_BLANK=12, CODE_ILLEGAL=15.
  - the FSM state enumeration.
- One sub-module, seg_pattern_decode: combinational seg→{code, illegal}. It is reusable by the driver's checkers.

## Test plan
- Reset, then drive frame 1,2,3,4 with 16-cycle windows and 16-cycle gaps → one frame_valid pulse per frame; char3..0 = 1,2,3,4; seg_err stays 0.
- STABLE_CYCLES=2; digit 2's window lasts 1 cycle → no frame_valid for that frame; chars hold the previous values.
- Digit 1 shows 1010101 → one seg_err pulse; next frame_valid has char1 = 15.
- an3=an2=0 for 4 cycles mid-frame → exactly one seg_err pulse; no frame_valid until a full new 3..0 sequence.
- Assert reset after digits 3 and 2 are captured, release, then send digits 1 and 0 only → no frame_valid; chars = C,C,C,C.
- With SEG_CAPTURE_ERRCNT_EN, 300 illegal digits → err_cnt = 255 and holds.
